// File: rtl/rhs_convert_sequencer_if.sv
// Start/data handshake between the convert sequencer and rhs_spi_master.
// The sequencer side uses the master modport; the SPI engine uses slave.
interface rhs_convert_sequencer_if;
  logic        spi_start;
  logic [31:0] spi_data_out;
  logic        spi_done;
  logic [31:0] spi_data_in;

  modport master (output spi_start, output spi_data_out,
                  input  spi_done,  input  spi_data_in);
  modport slave  (input  spi_start, input  spi_data_out,
                  output spi_done,  output spi_data_in);
endinterface

// File: rtl/rhs_convert_sequencer.sv
// Sweep scheduler: one CONVERT frame per enabled channel plus two flush frames,
// realigning each returned word with the channel issued two frames earlier.
module rhs_convert_sequencer #(
  parameter int          NUM_CH     = 16,
  parameter int          GAP_CYCLES = 4,
  parameter logic [31:0] DUMMY_CMD  = 32'hC0FF_0000,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sweep_start,
  input  logic [31:0]             ch_mask,
  rhs_convert_sequencer_if.master spi,
  output logic                    busy,
  output logic                    sample_valid,
  output logic [31:0]             sample_data,
  output logic [5:0]              sample_ch,
  output logic                    sweep_done,
  output logic                    sweep_overrun,
  output logic                    spi_timeout
);

  typedef enum logic [2:0] {IDLE, GAP, ISSUE, WAIT, DONE} state_t;

  localparam logic [31:0] CH_MASK = 32'hFFFF_FFFF >> (32 - NUM_CH);

  state_t      state;
  logic [31:0] pend;
  logic [1:0]  dummies;
  logic [7:0]  gap_cnt;
  logic [15:0] wait_cnt;
  logic [2:0]  tag_vld;
  logic [5:0]  tag_ch [3];
  logic [31:0] accept_mask;
  logic [5:0]  accept_ch;
  logic [5:0]  pend_ch;

  function automatic logic [5:0] lowest(input logic [31:0] m);
    lowest = '0;
    for (int i = 31; i >= 0; i--)
      if (m[i]) lowest = 6'(i);
  endfunction

  function automatic logic [31:0] convert(input logic [5:0] c);
    convert = {10'b0, c, 16'h0000};
  endfunction

  assign accept_mask = ch_mask & CH_MASK;
  assign accept_ch   = lowest(accept_mask);
  assign pend_ch     = lowest(pend);

  // Remaining channels are kept as a bitmask; the lowest set bit is the next CONVERT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      pend             <= '0;
      dummies          <= '0;
      gap_cnt          <= '0;
      wait_cnt         <= '0;
      tag_vld          <= '0;
      tag_ch[0]        <= '0;
      tag_ch[1]        <= '0;
      tag_ch[2]        <= '0;
      spi.spi_start    <= 1'b0;
      spi.spi_data_out <= '0;
      busy             <= 1'b0;
      sample_valid     <= 1'b0;
      sample_data      <= '0;
      sample_ch        <= '0;
      sweep_done       <= 1'b0;
      sweep_overrun    <= 1'b0;
      spi_timeout      <= 1'b0;
    end else begin
      spi.spi_start <= 1'b0;
      sample_valid  <= 1'b0;
      sweep_done    <= 1'b0;
      if (sweep_start && (state != IDLE || sweep_done))
        sweep_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sweep_start && !sweep_done) begin
            if (accept_mask == '0) begin
              sweep_done <= 1'b1;
            end else begin
              pend             <= accept_mask & ~(32'd1 << accept_ch);
              dummies          <= '0;
              busy             <= 1'b1;
              spi.spi_start    <= 1'b1;
              spi.spi_data_out <= convert(accept_ch);
              tag_vld          <= 3'b001;
              tag_ch[0]        <= accept_ch;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= 16'd1;
          state    <= WAIT;
        end
        // The returned word belongs to the frame pushed two issues before this one.
        WAIT: begin
          if (spi.spi_done) begin
            if (tag_vld[2]) begin
              sample_valid <= 1'b1;
              sample_data  <= spi.spi_data_in;
              sample_ch    <= tag_ch[2];
            end
            gap_cnt <= '0;
            if (pend == '0 && dummies == 2'd2) begin
              sweep_done <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end else begin
              state <= GAP;
            end
          end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
            spi_timeout <= 1'b1;
            busy        <= 1'b0;
            tag_vld     <= '0;
            pend        <= '0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            spi.spi_start <= 1'b1;
            state         <= ISSUE;
            tag_vld       <= {tag_vld[1:0], pend != '0};
            tag_ch[2]     <= tag_ch[1];
            tag_ch[1]     <= tag_ch[0];
            tag_ch[0]     <= pend_ch;
            if (pend != '0) begin
              spi.spi_data_out <= convert(pend_ch);
              pend             <= pend & ~(32'd1 << pend_ch);
            end else begin
              spi.spi_data_out <= DUMMY_CMD;
              dummies          <= dummies + 2'd1;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rhs_convert_sequencer.sv
// Directed bench for rhs_convert_sequencer with a behavioural RHS/SPI slave
// that answers each frame with the result of the CONVERT issued two frames earlier.
module tb_rhs_convert_sequencer;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        sweep_start = 1'b0;
  logic [31:0] ch_mask = '0;
  logic        busy, sample_valid, sweep_done, sweep_overrun, spi_timeout;
  logic [31:0] sample_data;
  logic [5:0]  sample_ch;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int withhold_at = -1;
  int frame_idx = 0;

  int n_starts = 0, n_done = 0, n_busy = 0, bad_spacing = 0, bad_lat = 0;
  int last_done = 0, sd_cyc = 0, sd_busy = 0;
  bit have_done = 0;
  int          samp_ch [$];
  logic [31:0] samp_data [$];
  logic [31:0] cmds [$];

  rhs_convert_sequencer_if sif ();

  rhs_convert_sequencer dut (
    .clk(clk), .rstn(rstn), .sweep_start(sweep_start), .ch_mask(ch_mask),
    .spi(sif), .busy(busy), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ch(sample_ch), .sweep_done(sweep_done), .sweep_overrun(sweep_overrun),
    .spi_timeout(spi_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] resp_of(input logic [31:0] c);
    if (c[31:30] == 2'b00) resp_of = 32'hA5A5_0000 | {26'b0, c[21:16]};
    else                   resp_of = 32'h0BAD_F00D;
  endfunction

  // Slave: fixed 3-cycle frame latency, optional withheld completion.
  initial begin : slave
    logic [31:0] h1, h2, resp;
    h1 = 32'hC0FF_0000;
    h2 = 32'hC0FF_0000;
    sif.spi_done = 1'b0;
    sif.spi_data_in = '0;
    forever begin
      @(negedge clk);
      if (sif.spi_start === 1'b1) begin
        frame_idx = frame_idx + 1;
        resp = resp_of(h2);
        h2 = h1;
        h1 = sif.spi_data_out;
        if (frame_idx != withhold_at) begin
          repeat (3) @(posedge clk);
          #1 sif.spi_done = 1'b1;
          sif.spi_data_in = resp;
          @(posedge clk);
          #1 sif.spi_done = 1'b0;
        end
      end
    end
  end

  // Passive monitor: frames, samples, spacing and latency bookkeeping.
  always @(negedge clk) begin
    if (sif.spi_start === 1'b1) begin
      n_starts++;
      cmds.push_back(sif.spi_data_out);
      if (have_done && (cyc - last_done != GAP + 1)) bad_spacing++;
    end
    if (sif.spi_done === 1'b1 && busy === 1'b1) begin
      last_done = cyc;
      have_done = 1;
    end
    if (busy !== 1'b1) have_done = 0;
    if (busy === 1'b1) n_busy++;
    if (sample_valid === 1'b1) begin
      samp_ch.push_back(int'(sample_ch));
      samp_data.push_back(sample_data);
      if (cyc != last_done + 1) bad_lat++;
    end
    if (sweep_done === 1'b1) begin
      n_done++;
      sd_cyc = cyc;
      sd_busy = int'(busy);
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_sweep(input logic [31:0] m);
    @(posedge clk);
    #1 sweep_start = 1'b1;
    ch_mask = m;
    @(posedge clk);
    #1 sweep_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
    end
    check_output(tag, {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_nth_start(input int n, output int got);
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (sif.spi_start === 1'b1) got++;
      if (got == n) break;
    end
  endtask

  initial begin : main
    int bs, bsamp, bd, bb, got, s_cyc, t_cyc;

    // Reset state
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_spi_start", {31'b0, sif.spi_start}, 0);
    check_output("rst_spi_data_out", sif.spi_data_out, 0);
    check_output("rst_busy", {31'b0, busy}, 0);
    check_output("rst_sample_valid", {31'b0, sample_valid}, 0);
    check_output("rst_sample_data", sample_data, 0);
    check_output("rst_sample_ch", {26'b0, sample_ch}, 0);
    check_output("rst_sweep_done", {31'b0, sweep_done}, 0);
    check_output("rst_overrun", {31'b0, sweep_overrun}, 0);
    check_output("rst_timeout", {31'b0, spi_timeout}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);

    // Full mask sweep
    $display("[TB] full mask sweep");
    bs = n_starts; bsamp = samp_ch.size(); bd = n_done;
    start_sweep(32'hFFFF);
    check_output("t1_busy_t1", {31'b0, busy}, 1);
    check_output("t1_start_t1", {31'b0, sif.spi_start}, 1);
    wait_idle("t1_idle");
    check_output("t1_starts", n_starts - bs, 18);
    check_output("t1_samples", samp_ch.size() - bsamp, 16);
    for (int i = 0; i < 16; i++) begin
      check_output($sformatf("t1_ch%0d", i), samp_ch[bsamp + i], i);
      check_output($sformatf("t1_data%0d", i), samp_data[bsamp + i], 32'hA5A5_0000 + i);
    end
    check_output("t1_sweep_done", n_done - bd, 1);
    check_output("t1_done_lat", sd_cyc - last_done, 1);
    check_output("t1_done_busy", sd_busy, 0);
    check_output("t1_gap_spacing", bad_spacing, 0);
    check_output("t1_sample_lat", bad_lat, 0);

    // Sparse mask 0x8021
    $display("[TB] sparse mask sweep");
    bs = n_starts; bsamp = samp_ch.size();
    start_sweep(32'h0000_8021);
    wait_idle("t2_idle");
    check_output("t2_starts", n_starts - bs, 5);
    check_output("t2_cmd0", cmds[bs + 0], 32'h0000_0000);
    check_output("t2_cmd1", cmds[bs + 1], 32'h0005_0000);
    check_output("t2_cmd2", cmds[bs + 2], 32'h000F_0000);
    check_output("t2_cmd3", cmds[bs + 3], 32'hC0FF_0000);
    check_output("t2_cmd4", cmds[bs + 4], 32'hC0FF_0000);
    check_output("t2_samples", samp_ch.size() - bsamp, 3);
    check_output("t2_ch0", samp_ch[bsamp + 0], 0);
    check_output("t2_ch1", samp_ch[bsamp + 1], 5);
    check_output("t2_ch2", samp_ch[bsamp + 2], 15);
    check_output("t2_data2", samp_data[bsamp + 2], 32'hA5A5_000F);

    // Zero mask, including bits above NUM_CH that must be ignored
    $display("[TB] empty mask sweep");
    bs = n_starts; bd = n_done; bb = n_busy;
    start_sweep(32'hFFFF_0000);
    check_output("t3_done_t1", {31'b0, sweep_done}, 1);
    check_output("t3_busy_t1", {31'b0, busy}, 0);
    repeat (10) @(negedge clk);
    check_output("t3_starts", n_starts - bs, 0);
    check_output("t3_busy_cycles", n_busy - bb, 0);
    check_output("t3_done_count", n_done - bd, 1);

    // Overrun at the third frame
    $display("[TB] overrun sweep");
    check_output("t4_overrun_pre", {31'b0, sweep_overrun}, 0);
    bs = n_starts; bsamp = samp_ch.size(); bd = n_done;
    start_sweep(32'hFFFF);
    wait_nth_start(2, got);
    check_output("t4_third_start", got, 2);
    sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    check_output("t4_overrun", {31'b0, sweep_overrun}, 1);
    wait_idle("t4_idle");
    check_output("t4_starts", n_starts - bs, 18);
    check_output("t4_samples", samp_ch.size() - bsamp, 16);
    check_output("t4_ch15", samp_ch[bsamp + 15], 15);
    check_output("t4_done", n_done - bd, 1);

    // Timeout on frame 4
    $display("[TB] timeout sweep");
    withhold_at = frame_idx + 4;
    bd = n_done;
    start_sweep(32'hFFFF);
    wait_nth_start(3, got);
    check_output("t5_fourth_start", got, 3);
    s_cyc = cyc;
    t_cyc = -1;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      #1;
      if (spi_timeout === 1'b1) begin
        t_cyc = cyc;
        break;
      end
    end
    check_output("t5_timeout_lat", t_cyc - s_cyc, 1024);
    check_output("t5_busy", {31'b0, busy}, 0);
    repeat (20) @(negedge clk);
    check_output("t5_no_done", n_done - bd, 0);
    withhold_at = -1;
    bsamp = samp_ch.size();
    start_sweep(32'h0000_0030);
    check_output("t5_cmd_first", sif.spi_data_out, 32'h0004_0000);
    wait_idle("t5_idle");
    check_output("t5_samples", samp_ch.size() - bsamp, 2);
    check_output("t5_ch0", samp_ch[bsamp + 0], 4);
    check_output("t5_data1", samp_data[bsamp + 1], 32'hA5A5_0005);

    // Reset during frame 7
    $display("[TB] reset mid sweep");
    start_sweep(32'hFFFF);
    wait_nth_start(6, got);
    check_output("t6_seventh_start", got, 6);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_output("t6_busy", {31'b0, busy}, 0);
    check_output("t6_spi_data_out", sif.spi_data_out, 0);
    check_output("t6_spi_start", {31'b0, sif.spi_start}, 0);
    check_output("t6_sample_data", sample_data, 0);
    check_output("t6_sample_ch", {26'b0, sample_ch}, 0);
    check_output("t6_overrun", {31'b0, sweep_overrun}, 0);
    check_output("t6_timeout", {31'b0, spi_timeout}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) @(posedge clk);
    bsamp = samp_ch.size();
    start_sweep(32'hFFFF);
    wait_idle("t6_idle");
    check_output("t6_samples", samp_ch.size() - bsamp, 16);
    for (int i = 0; i < 16; i++)
      check_output($sformatf("t6_ch%0d", i), samp_ch[bsamp + i], i);
    check_output("t6_data7", samp_data[bsamp + 7], 32'hA5A5_0007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rhs_convert_sequencer.md
# rhs_convert_sequencer

Frame-level scheduler sitting between the acquisition control logic and `rhs_spi_master`. On each sweep trigger it issues one CONVERT frame per enabled channel, then two dummy frames to flush the RHS 2-frame result pipeline. It realigns every returned word with the channel that produced it and emits tagged samples. It owns the master's start/data handshake exclusively; no other block drives the master while the sequencer is busy.

## Interface
- `NUM_CH`, 16: channels per sweep, legal 1..32; channel indices 0..NUM_CH-1.
- `GAP_CYCLES`, 4: idle clk cycles between the `spi_done` of one frame and the next `spi_start` (CS-high time); legal 1..255.
- `DUMMY_CMD`, 32'hC0FF_0000: command word for the two flush frames.
- `TIMEOUT`, 1024: max clk cycles from `spi_start` to `spi_done` before abort; legal 2..65535.
- `clk` in 1: system clock, 112 MHz nominal.
- `rstn` in 1: asynchronous active-low reset.
- `sweep_start` in 1: single-cycle sweep request.
- `ch_mask` in 32: per-channel enable; bits >= NUM_CH ignored; sampled at sweep acceptance.
- `spi_start` out 1: single-cycle frame start to master.
- `spi_data_out` out 32: command word to master; valid and stable from `spi_start` through `spi_done`.
- `spi_done` in 1: single-cycle frame-complete from master.
- `spi_data_in` in 32: MISO word from master; valid in the `spi_done` cycle.
- `busy` out 1: sweep in progress.
- `sample_valid` out 1: single-cycle sample strobe.
- `sample_data` out 32: realigned result word.
- `sample_ch` out 6: channel tag of `sample_data`.
- `sweep_done` out 1: single-cycle pulse at normal sweep completion.
- `sweep_overrun` out 1: sticky; set when `sweep_start` arrives while `busy`; cleared only by reset.
- `spi_timeout` out 1: sticky; set on timeout abort; cleared only by reset.

## Operation
- Command word: CONVERT(c) = {2'b00, 4'b0000, 4'b0000, c[5:0], 16'h0000}.
- States: IDLE, GAP, ISSUE, WAIT, DONE.
- IDLE
  - Accept `sweep_start`: latch `ch_mask & ((1<<NUM_CH)-1)`.
  - If the latched mask is zero: no frames are issued; pulse `sweep_done` the next cycle and stay IDLE.
  - Otherwise build the frame list (enabled channels in ascending order, then 2 dummies), set `busy`, and go to ISSUE.
- ISSUE
  - Drive `spi_start`=1 for one cycle with `spi_data_out` = current frame's command.
  - Push the frame's tag into a 3-entry tag pipeline: the channel for CONVERT frames, the flag "none" for dummies.
  - Go to WAIT.
- WAIT
  - Count cycles.
  - On `spi_done`: the word belongs to the tag issued 2 frames earlier. If that tag is a channel, pulse `sample_valid` the next cycle with `sample_data` = `spi_data_in` and `sample_ch` = that tag.
  - After `spi_done`: go to DONE if this was the last frame, else go to GAP.
  - If the count reaches TIMEOUT with no `spi_done`: set `spi_timeout`, clear `busy`, discard the tag pipeline, go to IDLE. No `sweep_done` is pulsed.
- GAP: wait GAP_CYCLES cycles, then go to ISSUE.
- DONE: pulse `sweep_done` for one cycle, clear `busy`, go to IDLE.
- The first two responses of a sweep correspond to no valid command and are dropped. The tag pipeline resets at each sweep start.
- Responses from dummy frames whose realigned tag is a channel are emitted. Number of emitted samples = popcount of the latched mask.
- `sweep_start` during `busy`: ignored and sets `sweep_overrun`.
- `spi_done` outside WAIT: ignored.
- Reset mid-sweep: every output returns immediately to its reset value; the master is left to finish its frame, and its `spi_done` is ignored in IDLE.

## Timing
- Reset values: `spi_start`=0, `spi_data_out`=0, `busy`=0, `sample_valid`=0, `sample_data`=0, `sample_ch`=0, `sweep_done`=0, `sweep_overrun`=0, `spi_timeout`=0.
- `sweep_start` at cycle T (nonzero mask):
  - `busy`=1 from T+1.
  - First `spi_start` at T+1.
- `sample_valid` occurs 1 cycle after the corresponding `spi_done`.
- `spi_start` spacing: the next `spi_start` is exactly GAP_CYCLES+1 cycles after the previous `spi_done`.
- `sweep_done` occurs 1 cycle after the final `spi_done`. `busy` falls in the same cycle as `sweep_done`.
- A `sweep_start` in the same cycle as `sweep_done` counts as overrun.
- Frames per sweep = popcount(mask)+2.

## Test plan
- NUM_CH=16, mask=32'hFFFF, slave model returns {16'hA5A5, 10'b0, ch} for the convert issued 2 frames prior:
  - 18 `spi_start` pulses.
  - 16 samples with ch 0..15 in order, each `sample_data` matching its tag.
  - One `sweep_done`.
- mask=32'h0000_8021:
  - 5 frames (CONVERT 0, 5, 15, dummy, dummy).
  - Samples tagged 0, 5, 15.
- mask=0: no `spi_start`, `sweep_done` at T+1, `busy` never asserted.
- Second `sweep_start` at the 3rd `spi_start`: `sweep_overrun`=1; the sweep completes normally with 16 samples.
- Slave withholds `spi_done` on frame 4 (TIMEOUT=1024):
  - `spi_timeout`=1 at 1024 cycles after that `spi_start`.
  - `busy`=0, no `sweep_done`.
  - A subsequent sweep runs correctly.
- `rstn` pulsed low during frame 7: all outputs at reset values within the reset cycle; the next sweep yields 16 correctly tagged samples.
